// File: rtl/microcode_sequencer.sv
// Table-driven microcode sequencer for the SR-1 CPU: fetch handshake, microcycle counter, wait stalls.
// Define UCODE_WRITE_EN for a RAM control store written in IDLE; otherwise the built-in ROM image is used.
module microcode_sequencer #(
    parameter int OPCODE_W = 6,
    parameter int CYCLE_W  = 5,
    parameter int UCODE_W  = 6,
    parameter int NUM_WAIT = 8,
    parameter int END_CODE = 0,
    localparam int WAIT_IDX_W = (NUM_WAIT > 1) ? $clog2(NUM_WAIT) : 1,
    localparam int ENTRY_W    = 1 + WAIT_IDX_W + UCODE_W,
    localparam int ADDR_W     = OPCODE_W + CYCLE_W
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                run,
    input  logic                halt,
    output logic                instr_req,
    input  logic                instr_ack,
    input  logic [OPCODE_W-1:0] instr_opcode,
    input  logic [NUM_WAIT-1:0] wait_in,
    output logic [UCODE_W-1:0]  ucode,
    output logic                ucode_valid,
    output logic                instr_done,
    output logic [CYCLE_W-1:0]  cycle,
    output logic                ovf_err,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [ENTRY_W-1:0]  wr_data
);

    typedef enum logic [2:0] {IDLE, FETCH, READ, ISSUE, WAIT} state_t;

    state_t                state, state_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    logic [CYCLE_W-1:0]    cycle_d;
    logic                  ovf_d;
    logic [ENTRY_W-1:0]    rd_entry;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  e_wait_en;
    logic [WAIT_IDX_W-1:0] e_wait_idx;
    logic [UCODE_W-1:0]    e_op;
    logic                  released;

    assign e_wait_en  = rd_entry[ENTRY_W-1];
    assign e_wait_idx = rd_entry[UCODE_W +: WAIT_IDX_W];
    assign e_op       = rd_entry[UCODE_W-1:0];
    assign released   = !e_wait_en || wait_in[e_wait_idx];

    // Reading at the next-state address keeps the registered entry aligned with {opcode_q, cycle}.
    assign rd_addr = {opcode_d, cycle_d};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            opcode_q <= '0;
            cycle    <= '0;
            ovf_err  <= 1'b0;
        end else begin
            state    <= state_d;
            opcode_q <= opcode_d;
            cycle    <= cycle_d;
            ovf_err  <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state;
        opcode_d    = opcode_q;
        cycle_d     = cycle;
        ovf_d       = ovf_err;
        instr_req   = 1'b0;
        ucode_valid = 1'b0;
        ucode       = '0;
        instr_done  = 1'b0;
        if (!halt) begin
            case (state)
                IDLE: begin
                    if (run) state_d = FETCH;
                end
                FETCH: begin
                    instr_req = 1'b1;
                    if (instr_ack) begin
                        opcode_d = instr_opcode;
                        cycle_d  = '0;
                        state_d  = READ;
                    end else if (!run) begin
                        state_d = IDLE;
                    end
                end
                READ: state_d = ISSUE;
                ISSUE, WAIT: begin
                    if (e_op == UCODE_W'(END_CODE)) begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end else if (!released) begin
                        state_d = WAIT;
                    end else begin
                        ucode_valid = 1'b1;
                        ucode       = e_op;
                        // Last slot issued without an end code: force the return to fetch.
                        if (&cycle) begin
                            ovf_d   = 1'b1;
                            state_d = FETCH;
                        end else begin
                            cycle_d = cycle + 1'b1;
                            state_d = ISSUE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef UCODE_WRITE_EN
    logic [ENTRY_W-1:0] mem [2**ADDR_W];

    // Read-first port: a same-address write this cycle is seen only on the next read.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && !halt) mem[wr_addr] <= wr_data;
        rd_entry <= mem[rd_addr];
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};

    function automatic logic [ENTRY_W-1:0] mk(input logic w, input int idx, input int op);
        mk = {w, WAIT_IDX_W'(idx), UCODE_W'(op)};
    endfunction

    // Microcode image: 1 = INC, PC_MAR; 2 = no end code; 3 = ops 11..15; 4 = end only; 5 = waits on channel 3.
    function automatic logic [ENTRY_W-1:0] rom_entry(input logic [ADDR_W-1:0] a);
        int op;
        int cyc;
        op        = int'(a[ADDR_W-1:CYCLE_W]);
        cyc       = int'(a[CYCLE_W-1:0]);
        rom_entry = mk(1'b0, 0, END_CODE);
        case (op)
            1: begin
                if (cyc == 0) rom_entry = mk(1'b0, 0, 1);
                if (cyc == 1) rom_entry = mk(1'b0, 0, 2);
            end
            2: rom_entry = mk(1'b0, 0, (cyc % ((1 << UCODE_W) - 1)) + 1);
            3: if (cyc < 5) rom_entry = mk(1'b0, 0, 11 + cyc);
            5: begin
                if (cyc == 0) rom_entry = mk(1'b1, 3, 9);
                if (cyc == 1) rom_entry = mk(1'b0, 0, 10);
            end
            default: rom_entry = mk(1'b0, 0, END_CODE);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        rd_entry <= rom_entry(rd_addr);
    end
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: directed programs, monitor pops expected issue/done events.
// Runs against the ROM image, or loads the same image when UCODE_WRITE_EN is defined.
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        run = 1'b0;
    logic        halt = 1'b0;
    logic        instr_req;
    logic        instr_ack = 1'b0;
    logic [5:0]  instr_opcode = '0;
    logic [7:0]  wait_in = '0;
    logic [5:0]  ucode;
    logic        ucode_valid;
    logic        instr_done;
    logic [4:0]  cycle;
    logic        ovf_err;
    logic        wr_en = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [9:0]  wr_data = '0;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic       done;
        logic [5:0] op;
        logic [4:0] cyc;
    } ev_t;

    ev_t exp_q[$];

    microcode_sequencer dut (
        .clk(clk), .n_reset(n_reset), .run(run), .halt(halt),
        .instr_req(instr_req), .instr_ack(instr_ack), .instr_opcode(instr_opcode),
        .wait_in(wait_in), .ucode(ucode), .ucode_valid(ucode_valid),
        .instr_done(instr_done), .cycle(cycle), .ovf_err(ovf_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: every issued micro-op or done pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (ucode_valid || instr_done) begin
            ev_t act;
            ev_t e;
            act = {instr_done, ucode, cycle};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_output: got done=%0b valid=%0b op=%0d cycle=%0d, required no output",
                         instr_done, ucode_valid, ucode, cycle);
            end else begin
                e = exp_q.pop_front();
                if (act !== e || ucode_valid !== !e.done) begin
                    bad++;
                    $display("[TB] FAIL scoreboard: got done=%0b valid=%0b op=%0d cycle=%0d, required done=%0b op=%0d cycle=%0d",
                             instr_done, ucode_valid, ucode, cycle, e.done, e.op, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic void push_ev(input bit d, input int op, input int c);
        exp_q.push_back({d, 6'(op), 5'(c)});
    endfunction

    function automatic logic [9:0] mk(input bit w, input int idx, input int op);
        return {w, 3'(idx), 6'(op)};
    endfunction

    task automatic write_entry(input int opc, input int cyc, input logic [9:0] data);
        wr_en   = 1'b1;
        wr_addr = {6'(opc), 5'(cyc)};
        wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Brings the sequencer to FETCH and acks the opcode; returns during the READ bubble.
    task automatic apply_stimulus(input int opc);
        int n;
        n   = 0;
        run = 1'b1;
        while (instr_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check_output("fetch_req", int'(instr_req), 1);
        instr_opcode = 6'(opc);
        instr_ack    = 1'b1;
        run          = 1'b0;
        tick();
        instr_ack = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) tick();
        check_output("reset_req", int'(instr_req), 0);
        check_output("reset_valid", int'(ucode_valid), 0);
        check_output("reset_done", int'(instr_done), 0);
        check_output("reset_cycle", int'(cycle), 0);
        check_output("reset_ovf", int'(ovf_err), 0);
        n_reset = 1'b1;
        tick();

`ifdef UCODE_WRITE_EN
        write_entry(1, 0, mk(0, 0, 1));
        write_entry(1, 1, mk(0, 0, 2));
        write_entry(1, 2, mk(0, 0, 0));
        for (int c = 0; c < 32; c++) write_entry(2, c, mk(0, 0, c + 1));
        for (int c = 0; c < 5; c++) write_entry(3, c, mk(0, 0, 11 + c));
        write_entry(3, 5, mk(0, 0, 0));
        write_entry(4, 0, mk(0, 0, 0));
        write_entry(4, 1, mk(0, 0, 0));
        write_entry(5, 0, mk(1, 3, 9));
        write_entry(5, 1, mk(0, 0, 10));
        write_entry(5, 2, mk(0, 0, 0));
`endif

        // Basic program: two ops, then end code, then fetch.
        push_ev(0, 1, 0);
        push_ev(0, 2, 1);
        push_ev(1, 0, 2);
        apply_stimulus(1);
        check_output("read_bubble", int'(ucode_valid), 0);
        tick();
        check_output("first_issue_latency", int'(ucode_valid), 1);
        tick();
        tick();
        check_output("done_pulse", int'(instr_done), 1);
        tick();
        check_output("req_after_done", int'(instr_req), 1);
        tick();
        check_output("idle_no_req", int'(instr_req), 0);

        // Waited entry stalls then issues in the same cycle the channel rises.
        push_ev(0, 9, 0);
        push_ev(0, 10, 1);
        push_ev(1, 0, 2);
        apply_stimulus(5);
        tick();
        for (int i = 0; i < 10; i++) begin
            check_output("wait_no_issue", int'(ucode_valid), 0);
            check_output("wait_cycle", int'(cycle), 0);
            tick();
        end
        wait_in[3] = 1'b1;
        #1;
        check_output("wait_release_same_cycle", int'(ucode_valid), 1);
        check_output("wait_release_op", int'(ucode), 9);
        tick();
        tick();
        tick();
        wait_in[3] = 1'b0;
        tick();

        // Program without an end code: 32 issues then forced fetch with sticky overflow.
        for (int c = 0; c < 32; c++) push_ev(0, c + 1, c);
        apply_stimulus(2);
        check_output("ovf_before", int'(ovf_err), 0);
        repeat (33) tick();
        check_output("ovf_set", int'(ovf_err), 1);
        check_output("ovf_fetch_req", int'(instr_req), 1);
        check_output("ovf_no_done", int'(instr_done), 0);
        tick();
        tick();
        check_output("ovf_sticky", int'(ovf_err), 1);

        // Halt for four cycles after the op at cycle 2; resume at cycle 3 with no skip or repeat.
        for (int c = 0; c < 5; c++) push_ev(0, 11 + c, c);
        push_ev(1, 0, 5);
        apply_stimulus(3);
        repeat (4) tick();
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_output("halt_no_valid", int'(ucode_valid), 0);
            check_output("halt_cycle_held", int'(cycle), 3);
            tick();
        end
        halt = 1'b0;
        #1;
        check_output("halt_resume_op", int'(ucode), 14);
        repeat (3) tick();
        tick();

        // Reset while waiting abandons the program.
        apply_stimulus(5);
        tick();
        tick();
        n_reset = 1'b0;
        #1;
        check_output("rst_valid", int'(ucode_valid), 0);
        check_output("rst_req", int'(instr_req), 0);
        check_output("rst_cycle", int'(cycle), 0);
        check_output("rst_ovf_cleared", int'(ovf_err), 0);
        tick();
        n_reset = 1'b1;
        repeat (3) tick();
        check_output("idle_after_rst_req", int'(instr_req), 0);
        check_output("idle_after_rst_valid", int'(ucode_valid), 0);

`ifdef UCODE_WRITE_EN
        // Write during execution must be ignored.
        for (int c = 0; c < 5; c++) push_ev(0, 11 + c, c);
        push_ev(1, 0, 5);
        apply_stimulus(3);
        tick();
        wr_en   = 1'b1;
        wr_addr = {6'd4, 5'd0};
        wr_data = mk(0, 0, 30);
        tick();
        wr_en = 1'b0;
        repeat (5) tick();
`else
        write_entry(4, 0, mk(0, 0, 30));
`endif
        // End-only program: done in the cycle after the READ bubble.
        push_ev(1, 0, 0);
        apply_stimulus(4);
        tick();
        check_output("end_only_done", int'(instr_done), 1);
        tick();
        tick();

`ifdef UCODE_WRITE_EN
        write_entry(4, 0, mk(0, 0, 30));
        push_ev(0, 30, 0);
        push_ev(1, 0, 1);
        apply_stimulus(4);
        repeat (4) tick();
`endif

        repeat (3) tick();
        check_output("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
